// File: rtl/dmem_map_pkg.sv
// Shared address map for the CPU data-memory port: RAM base, MMIO register
// addresses, STATUS bit layout and the decoded target selector.
package dmem_map_pkg;

  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h1001_0000;

  localparam logic [31:0] MMIO_LED    = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_TXDATA = 32'hFFFF_0004;
  localparam logic [31:0] MMIO_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] MMIO_CYCLES = 32'hFFFF_000C;

  localparam int ST_TX_VALID  = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_COUNT_LSB = 3;
  localparam int ST_COUNT_W   = 5;
  localparam int ST_OVERFLOW  = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_CYCLES
  } sel_e;

endpackage

// File: rtl/byte_fifo.sv
// Registered FIFO with no bypass. A push is accepted when there is room or
// when a pop frees a slot in the same cycle; a push into a full FIFO with no
// pop is dropped and latches a sticky overflow flag.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear_ovf,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  // Handshake qualification; the head reads as zero whenever nothing is queued
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;
    head    = empty ? '0 : mem[rd_ptr];
  end

  // Storage array is never reset; only the pointers and count define contents
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the single-cycle core's data port: word RAM plus
// an MMIO page (LED, TX byte FIFO, STATUS, free-running cycle counter).
// Reads are combinational from the address; every write lands on the clock edge.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
  parameter int          RAM_WORDS = 1024,
  parameter int          TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        dmem_r,
  input  logic        dmem_w,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_in,
  output logic [31:0] dmem_out,
  output logic [31:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      ram_off;
  logic [IDX_W-1:0] ram_idx;
  logic             active;
  logic             wr;
  logic             bad;
  sel_e             sel;
  logic [31:0]      cycles;
  logic [31:0]      status_word;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_overflow;
  logic [CNT_W-1:0] tx_count;

  // Address decode: unaligned addresses never hit anything, and an offset
  // below RAM_BASE wraps to a huge value so one unsigned compare bounds RAM
  always_comb begin
    active  = (dmem_r | dmem_w) & ena;
    wr      = active & dmem_w;
    ram_off = dmem_addr - RAM_BASE;
    ram_idx = ram_off[IDX_W+1:2];
    sel     = SEL_NONE;
    if (dmem_addr[1:0] == 2'b00) begin
      if (ram_off < RAM_BYTES) begin
        sel = SEL_RAM;
      end else begin
        case (dmem_addr)
          MMIO_LED:    sel = SEL_LED;
          MMIO_TXDATA: sel = SEL_TXDATA;
          MMIO_STATUS: sel = SEL_STATUS;
          MMIO_CYCLES: sel = SEL_CYCLES;
          default:     sel = SEL_NONE;
        endcase
      end
    end
    bad     = active & (sel == SEL_NONE);
    tx_push = wr & (sel == SEL_TXDATA);
    tx_pop  = tx_valid & tx_ready & ena;
  end

  // STATUS word assembly and the combinational read mux (pre-write values)
  always_comb begin
    status_word                                   = '0;
    status_word[ST_TX_VALID]                      = tx_valid;
    status_word[ST_EMPTY]                         = tx_empty;
    status_word[ST_FULL]                          = tx_full;
    status_word[ST_COUNT_LSB +: ST_COUNT_W]       = ST_COUNT_W'(tx_count);
    status_word[ST_OVERFLOW]                      = tx_overflow;
    dmem_out = '0;
    if (active) begin
      case (sel)
        SEL_RAM:    dmem_out = ram[ram_idx];
        SEL_LED:    dmem_out = led;
        SEL_STATUS: dmem_out = status_word;
        SEL_CYCLES: dmem_out = cycles;
        default:    dmem_out = '0;
      endcase
    end
  end

  // Data RAM contents are not reset
  always_ff @(posedge clk) begin
    if (wr && sel == SEL_RAM) begin
      ram[ram_idx] <= dmem_in;
    end
  end

  // LED, cycle counter (a store beats the increment) and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led    <= '0;
      cycles <= '0;
      err    <= 1'b0;
    end else if (ena) begin
      if (wr && sel == SEL_LED) led <= dmem_in;
      cycles <= (wr && sel == SEL_CYCLES) ? dmem_in : cycles + 32'd1;
      if (bad) err <= 1'b1;
    end
  end

  assign tx_valid = ~tx_empty;

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (dmem_in[7:0]),
    .pop       (tx_pop),
    .clear_ovf (wr && sel == SEL_STATUS),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .overflow  (tx_overflow)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: loads and TX bytes have their expected
// values queued at issue time and are checked by an independent monitor.
module tb_dmem_responder;
  import dmem_map_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        dmem_r;
  logic        dmem_w;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_in;
  logic [31:0] dmem_out;
  logic [31:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];

  localparam logic [31:0] ST_EMPTY_ONLY = 32'h0000_0002;
  localparam logic [31:0] ST_THREE      = 32'h0000_0019;
  localparam logic [31:0] ST_FULL8      = 32'h0000_0045;
  localparam logic [31:0] ST_FULL8_OVF  = 32'h0000_0145;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .dmem_r    (dmem_r),
    .dmem_w    (dmem_w),
    .dmem_addr (dmem_addr),
    .dmem_in   (dmem_in),
    .dmem_out  (dmem_out),
    .led       (led),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One access cycle: drive at posedge+1, hold through the next edge
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] exp);
    dmem_r    = r;
    dmem_w    = w;
    dmem_addr = addr;
    dmem_in   = data;
    if (r && ena) rd_q.push_back(exp);
    @(posedge clk);
    #1;
    dmem_r = 1'b0;
    dmem_w = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares loads and accepted TX bytes against the scoreboard
  always @(negedge clk) begin
    if (!rst && ena && dmem_r) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL load_unexpected: got %08h expected none", dmem_out);
      end else begin
        checkOutput("load", dmem_out, rd_q.pop_front());
      end
    end
    if (!rst && ena && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL tx_unexpected: got %02h expected none", tx_data);
      end else begin
        checkOutput("tx_byte", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; dmem_r = 1'b0; dmem_w = 1'b0;
    dmem_addr = '0; dmem_in = '0; tx_ready = 1'b0;
    idle(2);
    rst = 1'b0;

    // Dirty some state, then reset mid-run
    applyStimulus(0, 1, MMIO_LED, 32'hA5A5_0001, 0);
    applyStimulus(1, 0, MMIO_LED, 0, 32'hA5A5_0001);
    checkOutput("led_port", led, 32'hA5A5_0001);
    applyStimulus(0, 1, MMIO_TXDATA, 32'h0000_0077, 0);
    checkOutput("tx_valid_pre_rst", tx_valid, 1);
    applyStimulus(1, 0, 32'h1001_0001, 0, 0);
    checkOutput("err_misaligned", err, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_led", led, 0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_err", err, 0);
    idle(1);
    rst = 1'b0;
    applyStimulus(1, 0, MMIO_CYCLES, 0, 32'd0);
    applyStimulus(1, 0, MMIO_CYCLES, 0, 32'd1);
    applyStimulus(1, 0, MMIO_CYCLES, 0, 32'd2);
    applyStimulus(1, 0, MMIO_STATUS, 0, ST_EMPTY_ONLY);

    // RAM read/write, boundary word, and simultaneous read+write
    applyStimulus(0, 1, 32'h1001_0000, 32'h1234_5678, 0);
    applyStimulus(0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 0);
    applyStimulus(1, 0, 32'h1001_0004, 0, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h1001_0000, 0, 32'h1234_5678);
    applyStimulus(0, 1, 32'h1001_0FFC, 32'hCAFE_0FFC, 0);
    applyStimulus(1, 0, 32'h1001_0FFC, 0, 32'hCAFE_0FFC);
    applyStimulus(0, 1, 32'h1001_0008, 32'h1111_1111, 0);
    applyStimulus(1, 1, 32'h1001_0008, 32'h2222_2222, 32'h1111_1111);
    applyStimulus(1, 0, 32'h1001_0008, 0, 32'h2222_2222);

    // TX: three bytes held under stall, then drained in order
    applyStimulus(0, 1, MMIO_TXDATA, 32'h0000_0041, 0); tx_q.push_back(8'h41);
    applyStimulus(0, 1, MMIO_TXDATA, 32'h0000_0042, 0); tx_q.push_back(8'h42);
    applyStimulus(0, 1, MMIO_TXDATA, 32'h0000_0043, 0); tx_q.push_back(8'h43);
    applyStimulus(1, 0, MMIO_STATUS, 0, ST_THREE);
    idle(2);
    checkOutput("tx_head_held", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    idle(5);
    tx_ready = 1'b0;
    checkOutput("tx_drained_valid", tx_valid, 0);
    checkOutput("tx_q_drained", tx_q.size(), 0);
    applyStimulus(1, 0, MMIO_STATUS, 0, ST_EMPTY_ONLY);

    // TX: fill, overflow drop, push-while-pop at full, overflow clear
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, MMIO_TXDATA, 32'h50 + i, 0);
      tx_q.push_back(8'(8'h50 + i));
    end
    applyStimulus(1, 0, MMIO_STATUS, 0, ST_FULL8);
    applyStimulus(0, 1, MMIO_TXDATA, 32'h0000_0058, 0);
    applyStimulus(1, 0, MMIO_STATUS, 0, ST_FULL8_OVF);
    tx_ready = 1'b1;
    applyStimulus(0, 1, MMIO_TXDATA, 32'h0000_0059, 0); tx_q.push_back(8'h59);
    tx_ready = 1'b0;
    applyStimulus(1, 0, MMIO_STATUS, 0, ST_FULL8_OVF);
    applyStimulus(0, 1, MMIO_STATUS, 32'hFFFF_FFFF, 0);
    applyStimulus(1, 0, MMIO_STATUS, 0, ST_FULL8);
    tx_ready = 1'b1;
    idle(12);
    tx_ready = 1'b0;
    checkOutput("tx_full_drained", tx_valid, 0);
    checkOutput("tx_q_full_drained", tx_q.size(), 0);
    checkOutput("err_still_clear", err, 0);

    // Error cases: no side effects, sticky err
    applyStimulus(0, 1, MMIO_LED, 32'h00C0_FFEE, 0);
    applyStimulus(1, 0, 32'h1001_0002, 0, 32'd0);
    checkOutput("err_misaligned_load", err, 1);
    applyStimulus(0, 1, 32'h2000_0000, 32'h0000_1234, 0);
    applyStimulus(0, 1, 32'h1001_0006, 32'hBAD0_0006, 0);
    applyStimulus(0, 1, 32'h1001_1000, 32'hBAD0_1000, 0);
    applyStimulus(0, 1, 32'hFFFF_0001, 32'hBAD0_0001, 0);
    applyStimulus(1, 0, 32'h2000_0000, 0, 32'd0);
    applyStimulus(1, 0, 32'h1001_0004, 0, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h1001_0000, 0, 32'h1234_5678);
    applyStimulus(1, 0, MMIO_LED, 0, 32'h00C0_FFEE);
    idle(3);
    checkOutput("err_sticky", err, 1);

    // Cycle counter load and wrap, then freeze under ena=0
    applyStimulus(0, 1, MMIO_CYCLES, 32'hFFFF_FFFE, 0);
    applyStimulus(1, 0, MMIO_CYCLES, 0, 32'hFFFF_FFFE);
    applyStimulus(1, 0, MMIO_CYCLES, 0, 32'hFFFF_FFFF);
    applyStimulus(1, 0, MMIO_CYCLES, 0, 32'h0000_0000);
    ena = 1'b0;
    applyStimulus(0, 1, MMIO_CYCLES, 32'h0000_0055, 0);
    applyStimulus(0, 1, MMIO_LED, 32'h0000_0077, 0);
    applyStimulus(0, 1, MMIO_TXDATA, 32'h0000_0099, 0);
    dmem_r = 1'b1;
    dmem_addr = MMIO_CYCLES;
    #2;
    checkOutput("disabled_read_zero", dmem_out, 0);
    dmem_r = 1'b0;
    checkOutput("disabled_tx_valid", tx_valid, 0);
    checkOutput("disabled_led", led, 32'h00C0_FFEE);
    idle(1);
    ena = 1'b1;
    applyStimulus(1, 0, MMIO_CYCLES, 0, 32'd1);
    applyStimulus(1, 0, MMIO_CYCLES, 0, 32'd2);
    checkOutput("rd_q_empty", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
